// File: rtl/instruction_queue_register.sv
// Prefetch FIFO feeding an instruction register that is split into opcode (control) and operand (wbus).
// Latency: a word loaded on one edge can reach the IR on the next edge, so load to control takes 2 edges.
// Backpressure: none; a load into a full FIFO without advance is dropped and sets sticky overflow. Define IR_TRISTATE_EN for a 'z idle wbus.
module instruction_queue_register #(
    parameter int OPCODE_W  = 4,
    parameter int OPERAND_W = 4,
    parameter int DEPTH     = 4,
    localparam int INSTR_W  = OPCODE_W + OPERAND_W,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INSTR_W-1:0]   instruction,
    input  logic                 load,
    input  logic                 advance,
    input  logic                 send,
    output logic [OPERAND_W-1:0] wbus,
    output logic [OPCODE_W-1:0]  control,
    output logic                 valid,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_W-1:0]     count,
    output logic                 overflow
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [INSTR_W-1:0] ir;
    logic               push;
    logic               pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push = load && (!full || advance);
    assign pop  = advance && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= instruction;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ir       <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (load && full && !advance) begin
                overflow <= 1'b1;
            end
            // No bypass: an advance on an empty FIFO clears the IR even if a load lands now.
            if (advance) begin
                if (!empty) begin
                    ir    <= mem[rd_ptr];
                    valid <= 1'b1;
                end else begin
                    ir    <= '0;
                    valid <= 1'b0;
                end
            end
        end
    end

    // IR is held at zero whenever valid is low, so control needs no extra gating.
    assign control = ir[INSTR_W-1:OPERAND_W];

`ifdef IR_TRISTATE_EN
    assign wbus = (send && valid) ? ir[OPERAND_W-1:0] : {OPERAND_W{1'bz}};
`else
    assign wbus = (send && valid) ? ir[OPERAND_W-1:0] : '0;
`endif

endmodule

// File: tb/tb_instruction_queue_register.sv
// Directed vectors; the driver queues the expected post-edge state and a monitor compares at the following falling edge.
module tb_instruction_queue_register;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] instruction = 8'h00;
    logic       load = 1'b0;
    logic       advance = 1'b0;
    logic       send = 1'b0;
    logic [3:0] wbus;
    logic [3:0] control;
    logic       valid;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       overflow;

`ifdef IR_TRISTATE_EN
    localparam logic [3:0] IDLE = 4'bzzzz;
`else
    localparam logic [3:0] IDLE = 4'b0000;
`endif

    typedef struct {
        string      nm;
        int         cnt;
        bit         ful;
        bit         emp;
        bit         vld;
        bit         ovf;
        logic [3:0] ctl;
        logic [3:0] wb;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    instruction_queue_register #(
        .OPCODE_W (4),
        .OPERAND_W(4),
        .DEPTH    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .instruction(instruction),
        .load       (load),
        .advance    (advance),
        .send       (send),
        .wbus       (wbus),
        .control    (control),
        .valid      (valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: pops one expectation per falling edge once the driver has queued it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk(e.nm, "count",    32'(count),    32'(e.cnt));
                chk(e.nm, "full",     32'(full),     32'(e.ful));
                chk(e.nm, "empty",    32'(empty),    32'(e.emp));
                chk(e.nm, "valid",    32'(valid),    32'(e.vld));
                chk(e.nm, "overflow", 32'(overflow), 32'(e.ovf));
                chk(e.nm, "control",  {28'h0, control}, {28'h0, e.ctl});
                chk(e.nm, "wbus",     {28'h0, wbus},    {28'h0, e.wb});
            end
        end
    end

    // One clock of stimulus plus the state expected after that edge (with send still applied).
    task automatic cyc(input string nm, input bit r, input bit ld, input bit adv, input bit snd,
                       input logic [7:0] ins, input int ecnt, input bit ef, input bit ee,
                       input bit ev, input bit eo, input logic [3:0] ectl, input logic [3:0] ewb);
        exp_t e;
        @(negedge clk);
        #1;
        reset       = r;
        load        = ld;
        advance     = adv;
        send        = snd;
        instruction = ins;
        @(posedge clk);
        e.nm  = nm;
        e.cnt = ecnt;
        e.ful = ef;
        e.emp = ee;
        e.vld = ev;
        e.ovf = eo;
        e.ctl = ectl;
        e.wb  = ewb;
        sbq.push_back(e);
    endtask

    initial begin
        //   name         rst ld adv snd instr  cnt full empty vld ovf ctl   wbus
        cyc("reset",      1, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 4'h0, IDLE);
        // basic load / advance / send
        cyc("ld_0c",      0, 1, 0, 0, 8'h0C, 1, 0, 0, 0, 0, 4'h0, IDLE);
        cyc("adv_0c",     0, 0, 1, 0, 8'h00, 0, 0, 1, 1, 0, 4'h0, IDLE);
        cyc("send_0c",    0, 0, 0, 1, 8'h00, 0, 0, 1, 1, 0, 4'h0, 4'hC);
        cyc("nosend",     0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 4'h0, IDLE);
        // fill, overflow, drain
        cyc("ld_1a",      0, 1, 0, 0, 8'h1A, 1, 0, 0, 1, 0, 4'h0, IDLE);
        cyc("ld_2b",      0, 1, 0, 0, 8'h2B, 2, 0, 0, 1, 0, 4'h0, IDLE);
        cyc("ld_3c",      0, 1, 0, 0, 8'h3C, 3, 0, 0, 1, 0, 4'h0, IDLE);
        cyc("ld_4d",      0, 1, 0, 0, 8'h4D, 4, 1, 0, 1, 0, 4'h0, IDLE);
        cyc("ovf_5e",     0, 1, 0, 0, 8'h5E, 4, 1, 0, 1, 1, 4'h0, IDLE);
        cyc("pop_1",      0, 0, 1, 0, 8'h00, 3, 0, 0, 1, 1, 4'h1, IDLE);
        cyc("pop_2",      0, 0, 1, 1, 8'h00, 2, 0, 0, 1, 1, 4'h2, 4'hB);
        cyc("pop_3",      0, 0, 1, 0, 8'h00, 1, 0, 0, 1, 1, 4'h3, IDLE);
        cyc("pop_4",      0, 0, 1, 0, 8'h00, 0, 0, 1, 1, 1, 4'h4, IDLE);
        cyc("pop_empty",  0, 0, 1, 1, 8'h00, 0, 0, 1, 0, 1, 4'h0, IDLE);
        cyc("reset2",     1, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 4'h0, IDLE);
        // full FIFO with simultaneous load+advance, pointer wrap
        cyc("ld_81",      0, 1, 0, 0, 8'h81, 1, 0, 0, 0, 0, 4'h0, IDLE);
        cyc("ld_92",      0, 1, 0, 0, 8'h92, 2, 0, 0, 0, 0, 4'h0, IDLE);
        cyc("ld_a3",      0, 1, 0, 0, 8'hA3, 3, 0, 0, 0, 0, 4'h0, IDLE);
        cyc("ld_b4",      0, 1, 0, 0, 8'hB4, 4, 1, 0, 0, 0, 4'h0, IDLE);
        cyc("ldadv_6f",   0, 1, 1, 0, 8'h6F, 4, 1, 0, 1, 0, 4'h8, IDLE);
        cyc("pop_9",      0, 0, 1, 0, 8'h00, 3, 0, 0, 1, 0, 4'h9, IDLE);
        cyc("pop_a",      0, 0, 1, 0, 8'h00, 2, 0, 0, 1, 0, 4'hA, IDLE);
        cyc("pop_b",      0, 0, 1, 0, 8'h00, 1, 0, 0, 1, 0, 4'hB, IDLE);
        cyc("pop_6f",     0, 0, 1, 1, 8'h00, 0, 0, 1, 1, 0, 4'h6, 4'hF);
        // empty FIFO with simultaneous load+advance: no bypass
        cyc("ldadv_71",   0, 1, 1, 0, 8'h71, 1, 0, 0, 0, 0, 4'h0, IDLE);
        cyc("send_inval", 0, 0, 0, 1, 8'h00, 1, 0, 0, 0, 0, 4'h0, IDLE);
        cyc("pop_71",     0, 0, 1, 1, 8'h00, 0, 0, 1, 1, 0, 4'h7, 4'h1);
        cyc("pop_empty2", 0, 0, 1, 0, 8'h00, 0, 0, 1, 0, 0, 4'h0, IDLE);
        // reset mid-operation, load during reset ignored
        cyc("ld_c1",      0, 1, 0, 0, 8'hC1, 1, 0, 0, 0, 0, 4'h0, IDLE);
        cyc("ld_d2",      0, 1, 0, 0, 8'hD2, 2, 0, 0, 0, 0, 4'h0, IDLE);
        cyc("ld_e3",      0, 1, 0, 0, 8'hE3, 3, 0, 0, 0, 0, 4'h0, IDLE);
        cyc("ld_f4",      0, 1, 0, 0, 8'hF4, 4, 1, 0, 0, 0, 4'h0, IDLE);
        cyc("ovf_55",     0, 1, 0, 0, 8'h55, 4, 1, 0, 0, 1, 4'h0, IDLE);
        cyc("pop_c1",     0, 0, 1, 0, 8'h00, 3, 0, 0, 1, 1, 4'hC, IDLE);
        cyc("rst_ld",     1, 1, 1, 1, 8'h99, 0, 0, 1, 0, 0, 4'h0, IDLE);
        cyc("post_rst",   0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 4'h0, IDLE);
        cyc("ld_2a",      0, 1, 0, 0, 8'h2A, 1, 0, 0, 0, 0, 4'h0, IDLE);
        cyc("pop_2a",     0, 0, 1, 1, 8'h00, 0, 0, 1, 1, 0, 4'h2, 4'hA);

        for (int i = 0; i < 10 && sbq.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
